// File: rtl/pcm_rx_pkg.sv
// Shared encodings for the PCM receive capture block: serial format codes,
// capture FSM states and the per-slot bit counter width.
package pcm_rx_pkg;

  localparam logic FMT_I2S = 1'b0;
  localparam logic FMT_LJ  = 1'b1;

  localparam int BITCNT_W = 6;
  localparam logic [BITCNT_W-1:0] BITCNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEEK  = 2'd1,
    ST_CAP_L = 2'd2,
    ST_CAP_R = 2'd3
  } state_t;

endpackage

// File: rtl/pcm_frame_fifo.sv
// First-word-fall-through frame FIFO. The head entry is always visible on
// o_data. A push into a full FIFO is taken only when a pop frees a slot in
// the same cycle.
module pcm_frame_fifo
  import pcm_rx_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rptr];
  assign o_level   = r_level;

  // Storage array: written on accepted pushes only, never reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
      else if (!w_do_push && w_do_pop) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/pcm_rx_capture.sv
// Stereo ADC receive front end: oversamples the master-mode serial bus,
// decodes I2S or left-justified slots, queues complete {L,R} frames and
// drives the ADC strap pins from configuration.
module pcm_rx_capture
  import pcm_rx_pkg::*;
#(
  parameter int SAMPLE_W   = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_fmt_sel,
  input  logic [1:0]          i_md_sel,
  input  logic                i_bck,
  input  logic                i_lrck,
  input  logic                i_adata,
  output logic                o_adc_fmt,
  output logic                o_adc_md1,
  output logic                o_adc_md2,
  output logic                o_frame_valid,
  input  logic                i_frame_ready,
  output logic [SAMPLE_W-1:0] o_lword,
  output logic [SAMPLE_W-1:0] o_rword,
  output logic [LVL_W-1:0]    o_fifo_level,
  output logic                o_locked,
  output logic                o_ovf,
  output logic [CNT_W-1:0]    o_ovf_cnt,
  input  logic                i_ovf_clr
);

  logic [1:0]            r_bck_sync, r_lrck_sync, r_adata_sync;
  logic                  r_bck_prev, r_lrck_prev;
  logic [SAMPLE_W-1:0]   r_word, r_lword, r_rword;
  logic [BITCNT_W-1:0]   r_bitcnt;
  state_t                r_state;
  logic                  r_push, r_locked, r_ovf;
  logic [CNT_W-1:0]      r_ovf_cnt;
  logic                  r_adc_fmt, r_adc_md1, r_adc_md2;

  logic                  w_bre, w_lrck, w_adata, w_boundary;
  logic [SAMPLE_W-1:0]   w_word_ins, w_closed, w_lj_first;
  logic [2*SAMPLE_W-1:0] w_head;
  logic                  w_full, w_empty, w_pop, w_drop;

  // Two-stage synchronisers on the asynchronous bus, plus bck history for edge detect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bck_sync   <= '0;
      r_lrck_sync  <= '0;
      r_adata_sync <= '0;
      r_bck_prev   <= 1'b0;
    end else begin
      r_bck_sync   <= {r_bck_sync[0], i_bck};
      r_lrck_sync  <= {r_lrck_sync[0], i_lrck};
      r_adata_sync <= {r_adata_sync[0], i_adata};
      r_bck_prev   <= r_bck_sync[1];
    end
  end

  assign w_bre      = r_bck_sync[1] & ~r_bck_prev;
  assign w_lrck     = r_lrck_sync[1];
  assign w_adata    = r_adata_sync[1];
  assign w_boundary = w_bre & (w_lrck != r_lrck_prev);

  // Current word with this bre's bit dropped into its MSB-first position;
  // bits past SAMPLE_W match no position and are ignored.
  for (genvar gi = 0; gi < SAMPLE_W; gi++) begin : g_ins
    assign w_word_ins[gi] = (r_bitcnt == BITCNT_W'(SAMPLE_W - 1 - gi)) ? w_adata : r_word[gi];
  end

  // In I2S the boundary bit still belongs to the slot being closed.
  assign w_closed = (i_fmt_sel == FMT_I2S) ? w_word_ins : r_word;

  // In left-justified mode the boundary bit is the new slot's MSB.
  always_comb begin
    w_lj_first             = '0;
    w_lj_first[SAMPLE_W-1] = w_adata;
  end

  // Slot shifter and bit counter; runs on every bre so any slot can be picked up.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lrck_prev <= 1'b0;
      r_word      <= '0;
      r_bitcnt    <= '0;
    end else if (w_boundary) begin
      r_lrck_prev <= w_lrck;
      if (i_fmt_sel == FMT_LJ) begin
        r_word   <= w_lj_first;
        r_bitcnt <= BITCNT_W'(1);
      end else begin
        r_word   <= '0;
        r_bitcnt <= '0;
      end
    end else if (w_bre) begin
      r_lrck_prev <= w_lrck;
      r_word      <= w_word_ins;
      if (r_bitcnt != BITCNT_MAX) r_bitcnt <= r_bitcnt + 1'b1;
    end
  end

  // Frame FSM: align to a left slot, latch L then R, push one cycle after the closing bre.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_lword  <= '0;
      r_rword  <= '0;
      r_push   <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (!i_en) begin
        r_state  <= ST_IDLE;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_SEEK;
          ST_SEEK: if (w_boundary && !w_lrck) r_state <= ST_CAP_L;
          ST_CAP_L: begin
            if (w_boundary && w_lrck) begin
              r_lword <= w_closed;
              r_state <= ST_CAP_R;
            end
          end
          ST_CAP_R: begin
            if (w_boundary && !w_lrck) begin
              r_rword  <= w_closed;
              r_push   <= 1'b1;
              r_locked <= 1'b1;
              r_state  <= ST_CAP_L;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  pcm_frame_fifo #(
    .WIDTH (2 * SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (r_push),
    .i_data  ({r_lword, r_rword}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_fifo_level)
  );

  assign w_pop  = i_frame_ready & ~w_empty;
  assign w_drop = r_push & w_full & ~w_pop;

  // Sticky overflow flag and saturating drop counter; a clear beats a same-cycle drop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (i_ovf_clr) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_ovf_cnt != {CNT_W{1'b1}}) r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

  // ADC strap pins follow configuration with one clock of latency, regardless of en.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_adc_fmt <= 1'b0;
      r_adc_md1 <= 1'b0;
      r_adc_md2 <= 1'b0;
    end else begin
      r_adc_fmt <= i_fmt_sel;
      r_adc_md1 <= i_md_sel[0];
      r_adc_md2 <= i_md_sel[1];
    end
  end

  assign o_adc_fmt     = r_adc_fmt;
  assign o_adc_md1     = r_adc_md1;
  assign o_adc_md2     = r_adc_md2;
  assign o_frame_valid = ~w_empty;
  assign o_lword       = w_empty ? '0 : w_head[2*SAMPLE_W-1:SAMPLE_W];
  assign o_rword       = w_empty ? '0 : w_head[SAMPLE_W-1:0];
  assign o_locked      = r_locked;
  assign o_ovf         = r_ovf;
  assign o_ovf_cnt     = r_ovf_cnt;

endmodule

// File: tb/tb_pcm_rx_capture.sv
// Directed bench for pcm_rx_capture: drives the ADC serial bus bit by bit
// (8 clk per bck period) and checks frames, FIFO, overflow and straps.
module tb_pcm_rx_capture;

  localparam int SW    = 24;
  localparam int DEPTH = 8;
  localparam int CW    = 8;
  localparam int LVLW  = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n, en, fmt_sel, bck, lrck, adata, frame_ready, ovf_clr;
  logic [1:0] md_sel;
  logic adc_fmt, adc_md1, adc_md2, frame_valid, locked, ovf;
  logic [SW-1:0] lword, rword;
  logic [LVLW-1:0] fifo_level;
  logic [CW-1:0] ovf_cnt;

  int errors = 0;
  int checks = 0;
  logic bus_lj = 1'b0;
  logic prev_bit = 1'b0;

  always #5 clk = ~clk;

  pcm_rx_capture #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_fmt_sel(fmt_sel), .i_md_sel(md_sel),
    .i_bck(bck), .i_lrck(lrck), .i_adata(adata),
    .o_adc_fmt(adc_fmt), .o_adc_md1(adc_md1), .o_adc_md2(adc_md2),
    .o_frame_valid(frame_valid), .i_frame_ready(frame_ready),
    .o_lword(lword), .o_rword(rword), .o_fifo_level(fifo_level),
    .o_locked(locked), .o_ovf(ovf), .o_ovf_cnt(ovf_cnt), .i_ovf_clr(ovf_clr)
  );

  // Falling half of a bit period, then the rising bck edge. I2S data lags lrck by one bit.
  task automatic bit_rise(input logic lr, input logic b);
    bck = 1'b0; lrck = lr; adata = bus_lj ? b : prev_bit; prev_bit = b;
    repeat (4) @(negedge clk);
    bck = 1'b1;
  endtask

  task automatic bit_tail();
    repeat (4) @(negedge clk);
  endtask

  // Bits [first,last) of a slot holding val (dbits wide, MSB first, zero padded).
  task automatic send_bits(input logic lr, input logic [31:0] val, input int dbits,
                           input int first, input int last);
    logic [31:0] v;
    v = val << (32 - dbits);
    for (int i = 0; i < last; i++) begin
      if (i >= first) begin
        bit_rise(lr, (i < dbits) ? v[31] : 1'b0);
        bit_tail();
      end
      if (i < dbits) v = v << 1;
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int dbits, input int sbits);
    send_bits(1'b0, l, dbits, 0, sbits);
    send_bits(1'b1, r, dbits, 0, sbits);
  endtask

  task automatic start_capture(input logic lj, input logic f);
    en = 1'b0;
    repeat (3) @(negedge clk);
    fmt_sel = f; bus_lj = lj; prev_bit = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
    send_bits(1'b1, 32'h0, 1, 0, 4);
  endtask

  task automatic stop_capture();
    en = 1'b0; frame_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pop_one();
    $display("pop: lword=%h rword=%h level=%0d", lword, rword, fifo_level);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", frame_valid); end
    checks++; if (lword !== '0 || rword !== '0) begin errors++; $display("FAIL rst_words: got %h/%h want 0/0", lword, rword); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    checks++; if ({locked, ovf} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b want 00", {locked, ovf}); end
    checks++; if (ovf_cnt !== '0) begin errors++; $display("FAIL rst_ovf_cnt: got %0d want 0", ovf_cnt); end
    checks++; if ({adc_fmt, adc_md1, adc_md2} !== 3'b000) begin errors++; $display("FAIL rst_straps: got %b want 000", {adc_fmt, adc_md1, adc_md2}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({adc_fmt, adc_md1, adc_md2} !== 3'b111) begin errors++; $display("FAIL strap_follow: got %b want 111", {adc_fmt, adc_md1, adc_md2}); end
    md_sel = 2'b10; fmt_sel = 1'b0;
    #1;
    checks++; if (adc_md1 !== 1'b1) begin errors++; $display("FAIL strap_latency: md1 got %b want 1", adc_md1); end
    @(negedge clk);
    checks++; if ({adc_fmt, adc_md1, adc_md2} !== 3'b001) begin errors++; $display("FAIL strap_update: got %b want 001", {adc_fmt, adc_md1, adc_md2}); end
  endtask

  task automatic test_i2s32();
    start_capture(1'b0, 1'b0);
    send_frame(32'h123456, 32'hABCDEF, 24, 32);
    send_bits(1'b0, 32'h0, 1, 0, 2);
    repeat (4) @(negedge clk);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL i2s32_valid: got %b want 1", frame_valid); end
    checks++; if (lword !== 24'h123456) begin errors++; $display("FAIL i2s32_lword: got %h want 123456", lword); end
    checks++; if (rword !== 24'hABCDEF) begin errors++; $display("FAIL i2s32_rword: got %h want abcdef", rword); end
    checks++; if ({locked, ovf} !== 2'b10) begin errors++; $display("FAIL i2s32_flags: locked/ovf got %b want 10", {locked, ovf}); end
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL i2s32_level: got %0d want 1", fifo_level); end
    pop_one();
    checks++; if (fifo_level !== 4'd0 || frame_valid !== 1'b0) begin errors++; $display("FAIL i2s32_pop: level %0d valid %b want 0 0", fifo_level, frame_valid); end
    frame_ready = 1'b1;
    repeat (3) @(negedge clk);
    frame_ready = 1'b0;
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL empty_ready: level got %0d want 0", fifo_level); end
    stop_capture();
  endtask

  task automatic test_lj24();
    start_capture(1'b1, 1'b1);
    send_frame(32'h123456, 32'hABCDEF, 24, 24);
    send_bits(1'b0, 32'h0, 1, 0, 2);
    repeat (4) @(negedge clk);
    checks++; if (lword !== 24'h123456) begin errors++; $display("FAIL lj24_lword: got %h want 123456", lword); end
    checks++; if (rword !== 24'hABCDEF) begin errors++; $display("FAIL lj24_rword: got %h want abcdef", rword); end
    pop_one();
    stop_capture();
    // Same left-justified bus, decoded as I2S: one-bit shift plus the next slot's MSB.
    start_capture(1'b1, 1'b0);
    send_frame(32'h123456, 32'hABCDEF, 24, 24);
    send_bits(1'b0, 32'h0, 1, 0, 2);
    repeat (4) @(negedge clk);
    checks++; if (lword !== 24'h2468AD) begin errors++; $display("FAIL lj_as_i2s_lword: got %h want 2468ad", lword); end
    checks++; if (rword !== 24'h579BDE) begin errors++; $display("FAIL lj_as_i2s_rword: got %h want 579bde", rword); end
    pop_one();
    stop_capture();
  endtask

  task automatic test_slot16();
    start_capture(1'b0, 1'b0);
    send_frame(32'h1234, 32'h8001, 16, 16);
    send_bits(1'b0, 32'h0, 1, 0, 2);
    repeat (4) @(negedge clk);
    checks++; if (lword !== 24'h123400) begin errors++; $display("FAIL slot16_lword: got %h want 123400", lword); end
    checks++; if (rword !== 24'h800100) begin errors++; $display("FAIL slot16_rword: got %h want 800100", rword); end
    pop_one();
    stop_capture();
  endtask

  task automatic test_overflow();
    start_capture(1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) send_frame(32'h100000 + i, 32'h200000 + i, 24, 32);
    send_bits(1'b0, 32'h0, 1, 0, 2);
    repeat (4) @(negedge clk);
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    checks++; if (ovf_cnt !== 8'd2) begin errors++; $display("FAIL ovf_cnt: got %0d want 2", ovf_cnt); end
    for (int i = 1; i <= 8; i++) begin
      logic [SW-1:0] exp_l, exp_r;
      exp_l = 24'h100000 + 24'(i);
      exp_r = 24'h200000 + 24'(i);
      checks++; if (lword !== exp_l || rword !== exp_r) begin errors++; $display("FAIL ovf_order_%0d: got %h/%h want %h/%h", i, lword, rword, exp_l, exp_r); end
      pop_one();
    end
    checks++; if (fifo_level !== 4'd0 || frame_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: level %0d valid %b want 0 0", fifo_level, frame_valid); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0 || ovf_cnt !== '0) begin errors++; $display("FAIL ovf_clr: ovf %b cnt %0d want 0 0", ovf, ovf_cnt); end
    stop_capture();
  endtask

  task automatic test_full_pop();
    logic [31:0] l9, r9;
    int k;
    logic found;
    l9 = 32'h300009; r9 = 32'h400009;
    start_capture(1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) send_frame(32'h300000 + i, 32'h400000 + i, 24, 32);
    checks++; if (fifo_level !== 4'd7) begin errors++; $display("FAIL full_pre_level: got %0d want 7", fifo_level); end
    // Close frame 8 and find the clock on which its push lands.
    bit_rise(1'b0, l9[23]);
    found = 1'b0; k = 0;
    for (int c = 1; c <= 8; c++) begin
      if (!found) begin
        @(negedge clk);
        if (fifo_level == 4'd8) begin found = 1'b1; k = c; end
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL full_push_seen: level got %0d want 8 within 8 clk", fifo_level); k = 4; end
    bit_tail();
    send_bits(1'b0, l9, 24, 1, 32);
    send_bits(1'b1, r9, 24, 0, 32);
    // Close frame 9 while full, with ready high only on the push cycle.
    bit_rise(1'b0, 1'b0);
    repeat (k - 1) @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    bit_tail();
    repeat (2) @(negedge clk);
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_pop_level: got %0d want 8", fifo_level); end
    checks++; if (ovf !== 1'b0 || ovf_cnt !== '0) begin errors++; $display("FAIL full_pop_ovf: ovf %b cnt %0d want 0 0", ovf, ovf_cnt); end
    checks++; if (lword !== 24'h300002) begin errors++; $display("FAIL full_pop_head: got %h want 300002", lword); end
    for (int i = 0; i < 7; i++) pop_one();
    checks++; if (lword !== 24'h300009 || rword !== 24'h400009) begin errors++; $display("FAIL full_pop_tail: got %h/%h want 300009/400009", lword, rword); end
    pop_one();
    stop_capture();
  endtask

  task automatic test_en_drop();
    start_capture(1'b0, 1'b0);
    send_frame(32'h500001, 32'h600001, 24, 32);
    send_bits(1'b0, 32'h500002, 24, 0, 32);
    send_bits(1'b1, 32'h600002, 24, 0, 10);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL endrop_locked_before: got %b want 1", locked); end
    en = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL endrop_locked_clear: got %b want 0", locked); end
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL endrop_retain: level got %0d want 1", fifo_level); end
    send_bits(1'b1, 32'h600002, 24, 10, 20);
    en = 1'b1;
    send_bits(1'b1, 32'h600002, 24, 20, 32);
    send_frame(32'h500003, 32'h600003, 24, 32);
    send_bits(1'b0, 32'h0, 1, 0, 2);
    repeat (4) @(negedge clk);
    checks++; if (fifo_level !== 4'd2) begin errors++; $display("FAIL endrop_level: got %0d want 2", fifo_level); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL endrop_relock: got %b want 1", locked); end
    checks++; if (lword !== 24'h500001 || rword !== 24'h600001) begin errors++; $display("FAIL endrop_head1: got %h/%h want 500001/600001", lword, rword); end
    pop_one();
    checks++; if (lword !== 24'h500003 || rword !== 24'h600003) begin errors++; $display("FAIL endrop_head2: got %h/%h want 500003/600003", lword, rword); end
    pop_one();
    stop_capture();
  endtask

  task automatic test_reset_mid();
    md_sel = 2'b01;
    start_capture(1'b0, 1'b0);
    send_frame(32'h700001, 32'h800001, 24, 32);
    send_bits(1'b0, 32'h700002, 24, 0, 12);
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL rstmid_pre_level: got %0d want 1", fifo_level); end
    rst_n = 1'b0;
    #1;
    checks++; if (frame_valid !== 1'b0 || fifo_level !== '0) begin errors++; $display("FAIL rstmid_fifo: valid %b level %0d want 0 0", frame_valid, fifo_level); end
    checks++; if (lword !== '0 || rword !== '0) begin errors++; $display("FAIL rstmid_words: got %h/%h want 0/0", lword, rword); end
    checks++; if ({locked, ovf, adc_fmt, adc_md1, adc_md2} !== 5'b0 || ovf_cnt !== '0) begin errors++; $display("FAIL rstmid_flags: got %b cnt %0d want 00000 0", {locked, ovf, adc_fmt, adc_md1, adc_md2}, ovf_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (fifo_level !== '0 || frame_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after: level %0d valid %b want 0 0", fifo_level, frame_valid); end
    stop_capture();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; fmt_sel = 1'b1; md_sel = 2'b11;
    bck = 1'b0; lrck = 1'b0; adata = 1'b0; frame_ready = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_i2s32();
    test_lj24();
    test_slot16();
    test_overflow();
    test_full_pop();
    test_en_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcm_rx_capture.md
Name: pcm_rx_capture

Overview:
Parametrised successor to the stereo ADC front end. It oversamples the ADC master-mode serial bus (bck/lrck/adata) in the system clock domain and decodes I2S or left-justified frames at any slot width. It buffers complete stereo frames in a FIFO and presents them on a valid/ready stream. It also drives the ADC strap pins from runtime configuration and reports overflow and lock status.

Parameters:
SAMPLE_W, 24, bits captured per channel (MSB-first); output word width.
FIFO_DEPTH, 8, stereo frames buffered; power of two, at least 2.
CNT_W, 8, width of the saturating overflow counter.

Ports:
clk  in  1  system clock; must be at least 4x bck frequency.
rst  in  1  asynchronous, active-low reset.
en  in  1  capture enable.
fmt_sel  in  1  0 = I2S, 1 = left-justified.
md_sel  in  2  ADC mode straps.
bck  in  1  ADC bit clock (asynchronous).
lrck  in  1  ADC word clock (asynchronous); low = left.
adata  in  1  ADC serial data.
adc_fmt  out  1  equals fmt_sel, registered.
adc_md1  out  1  equals md_sel[0], registered.
adc_md2  out  1  equals md_sel[1], registered.
frame_valid  out  1  FIFO not empty.
frame_ready  in  1  consumer accepts the head frame.
lword  out  SAMPLE_W  head-frame left sample.
rword  out  SAMPLE_W  head-frame right sample.
fifo_level  out  clog2(FIFO_DEPTH)+1  frames currently held.
locked  out  1  at least one full frame captured since en rose.
ovf  out  1  sticky overflow flag.
ovf_cnt  out  CNT_W  count of dropped frames, saturating.
ovf_clr  in  1  single-cycle pulse; clears ovf and ovf_cnt.

Behaviour:
- Reset values: all outputs 0; adc_md1/adc_md2 also 0 until the first clk after reset release; FIFO empty; FSM in IDLE.
- Input sync: each of bck, lrck, adata passes through a 2-FF synchroniser. A bck rising edge ("bre") is a single-cycle strobe from the synchronised bck going 0->1. lrck and adata are sampled only on bre.
- Slot boundary: lrck sampled at bre differs from its value at the previous bre.
  - I2S: the adata bit sampled on the boundary bre is the last bit of the previous slot. The MSB of the new slot is the bit at the next bre.
  - Left-justified: the adata bit on the boundary bre is the MSB of the new slot.
- Bit capture: per-slot bit counter, 6 bits, saturating at 63. The first SAMPLE_W bits of a slot are shifted in MSB-first. Later bits are ignored. If a slot ends before SAMPLE_W bits, the remaining LSBs are zero-filled (left-justified result).
- FSM:
  - IDLE: entered on reset or when en=0. Goes to SEEK when en=1.
  - SEEK: waits for a slot boundary into the left channel (lrck now low). Goes to CAP_L; the bit on that bre is handled per format.
  - CAP_L: on a boundary into the right channel, latches the left word and goes to CAP_R.
  - CAP_R: on a boundary into the left channel, latches the right word, pushes {L,R}, sets locked, and goes to CAP_L.
  - en=0 in any state goes to IDLE within 1 cycle. The partial frame is discarded, FIFO contents are retained, and locked clears.
  - A format change while en=1 is undefined; software toggles en around it.
- Latency: the frame push occurs 1 clk after the closing bre. frame_valid asserts on the clk after the push.
- FIFO: synchronous, first-word-fall-through; lword/rword are valid whenever frame_valid=1. A pop occurs when frame_valid and frame_ready are both high.
- Full: a push while full and not popping is dropped. That sets ovf and increments ovf_cnt (saturating at all-ones). A push and pop in the same cycle while full are both accepted and the level is unchanged.
- Empty: frame_ready is ignored.
- ovf_clr wins over a same-cycle overflow: counter and flag end at 0.
- Config straps adc_fmt/adc_md1/adc_md2: registered copies of their inputs, 1 clk latency, independent of en.

Decomposition:
- Package pcm_rx_pkg: format encodings (FMT_I2S=0, FMT_LJ=1), FSM state enum (IDLE, SEEK, CAP_L, CAP_R), bit-counter width constant (6).
- Sub-module pcm_frame_fifo: synchronous FWFT FIFO, width 2*SAMPLE_W, depth FIFO_DEPTH, with push/pop/full/empty/level.
- Synchroniser, edge detect, shifter and FSM stay in the top level.

Test Plan:
- I2S, 32-bit slots, SAMPLE_W=24: send L=0x123456, R=0xABCDEF, each followed by 8 zero bits, ready=1 -> one frame with lword=0x123456, rword=0xABCDEF; locked=1; ovf=0.
- Left-justified, 24-bit slots, same data -> identical output. The same bus decoded with fmt_sel=0 gives a 1-bit-shifted value (e.g. 0x2468AC..) and must differ.
- 16-bit slots, L=0x1234, R=0x8001 -> lword=0x123400, rword=0x800100.
- ready=0, 10 frames, FIFO_DEPTH=8 -> fifo_level=8, ovf=1, ovf_cnt=2. Then ready=1 pops the first 8 frames in order. ovf_clr then zeroes ovf and ovf_cnt.
- Full FIFO, frame_ready=1 on the exact push cycle -> no drop, level stays 8, ovf_cnt unchanged.
- en dropped mid-CAP_R, then restarted mid-frame -> no partial frame emitted; capture resumes at the next left boundary. Asserting rst mid-frame -> all outputs 0, FIFO empty.
